// File: rtl/mem_byte_arbiter.sv
// ---------------------------------------------------------------------------
// mem_byte_arbiter
//
// Shares one byte-wide synchronous data RAM between two requesters:
// r0 (CPU load/store unit) and r1 (debug/DMA loader).  Requests are
// arbitrated round-robin.  Each byte/half/word access is split into
// sequential little-endian byte cycles on the RAM port.  Load data is
// sign- or zero-extended and returned with a one-cycle done pulse.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : misaligned half/word accesses skip the RAM and finish with err=1
//   undefined : misaligned accesses run byte-wise, err outputs stay 0
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_rN_req                access request, held until o_rN_gnt
//   i_rN_we                 1 = store, 0 = load
//   i_rN_size               00 byte, 01 half, 10 word, 11 illegal
//   i_rN_uns                loads: 1 = zero-extend, 0 = sign-extend
//   i_rN_addr               byte address (bits above ADDR_W ignored)
//   i_rN_wdata              store data, low bytes used per size
//   o_rN_gnt                request accepted; fields sampled this cycle
//   o_rN_done               one-cycle completion pulse
//   o_rN_rdata              load result, qualified by o_rN_done
//   o_rN_err                alignment error, qualified by o_rN_done
//   o_m_en/o_m_we           RAM byte access / write enable
//   o_m_addr, o_m_wdata     RAM byte address / write byte
//   i_m_rdata               RAM read byte, valid one cycle after a read
// ---------------------------------------------------------------------------
module mem_byte_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_r0_req,
    input  logic              i_r0_we,
    input  logic [1:0]        i_r0_size,
    input  logic              i_r0_uns,
    input  logic [31:0]       i_r0_addr,
    input  logic [31:0]       i_r0_wdata,
    output logic              o_r0_gnt,
    output logic              o_r0_done,
    output logic [31:0]       o_r0_rdata,
    output logic              o_r0_err,

    input  logic              i_r1_req,
    input  logic              i_r1_we,
    input  logic [1:0]        i_r1_size,
    input  logic              i_r1_uns,
    input  logic [31:0]       i_r1_addr,
    input  logic [31:0]       i_r1_wdata,
    output logic              o_r1_gnt,
    output logic              o_r1_done,
    output logic [31:0]       o_r1_rdata,
    output logic              o_r1_err,

    output logic              o_m_en,
    output logic              o_m_we,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [7:0]        o_m_wdata,
    input  logic [7:0]        i_m_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

    state_t              r_state;
    logic                r_last;
    logic                r_sel;
    logic                r_we;
    logic                r_uns;
    logic [1:0]          r_size;
    logic [1:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rbuf;

    logic                r_r0_done;
    logic                r_r1_done;
    logic [31:0]         r_r0_rdata;
    logic [31:0]         r_r1_rdata;
    logic                r_r0_err;
    logic                r_r1_err;
    logic                r_m_en;
    logic                r_m_we;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [7:0]          r_m_wdata;

    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_gnt;
    logic                w_pick;
    logic                w_we;
    logic [1:0]          w_size;
    logic                w_uns;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         w_wdata;
    logic                w_misal;
    logic                w_skip;
    logic [1:0]          w_lastIdx;
    logic [1:0]          w_capIdx;
    logic [31:0]         w_ldata;
    logic [31:0]         w_ext;
    logic                w_fin;
    logic                w_finSel;
    logic [31:0]         w_finData;
    logic                w_finErr;
    logic                w_unused;

    // Upper request address bits are intentionally ignored.
    assign w_unused = ^{i_r0_addr[31:ADDR_W], i_r1_addr[31:ADDR_W]};

    // Round-robin: on a conflict the requester that did not win last time
    // is granted.  Grant is only offered in IDLE and never during reset.
    assign w_gnt0 = (r_state == IDLE) && !i_rst && i_r0_req && (!i_r1_req || r_last);
    assign w_gnt1 = (r_state == IDLE) && !i_rst && i_r1_req && (!i_r0_req || !r_last);
    assign w_gnt  = w_gnt0 || w_gnt1;
    assign w_pick = w_gnt1;

    assign w_we    = w_pick ? i_r1_we    : i_r0_we;
    assign w_size  = w_pick ? i_r1_size  : i_r0_size;
    assign w_uns   = w_pick ? i_r1_uns   : i_r0_uns;
    assign w_addr  = w_pick ? i_r1_addr[ADDR_W-1:0] : i_r0_addr[ADDR_W-1:0];
    assign w_wdata = w_pick ? i_r1_wdata : i_r0_wdata;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misal = ((w_size == 2'b01) && w_addr[0]) ||
                     ((w_size == 2'b10) && (w_addr[1:0] != 2'b00));
`else
    assign w_misal = 1'b0;
`endif

    // Accesses that never touch the RAM go straight to DONE.
    assign w_skip = (w_size == 2'b11) || w_misal;

    // Index of the final byte of the latched access.
    always_comb begin
        case (r_size)
            2'b00:   w_lastIdx = 2'd0;
            2'b01:   w_lastIdx = 2'd1;
            default: w_lastIdx = 2'd3;
        endcase
    end

    // The RAM byte arriving now belongs to the previous XFER cycle, except
    // in DRAIN where the counter was held on the final byte.
    assign w_capIdx = (r_state == DRAIN) ? r_cnt : (r_cnt - 2'd1);

    // Merge the arriving byte into the assembly buffer and extend the
    // result according to size and signedness.
    always_comb begin
        w_ldata = r_rbuf;
        w_ldata[{w_capIdx, 3'b000} +: 8] = i_m_rdata;
        case (r_size)
            2'b00:   w_ext = r_uns ? {24'h000000, w_ldata[7:0]}
                                   : {{24{w_ldata[7]}}, w_ldata[7:0]};
            2'b01:   w_ext = r_uns ? {16'h0000, w_ldata[15:0]}
                                   : {{16{w_ldata[15]}}, w_ldata[15:0]};
            default: w_ext = w_ldata;
        endcase
    end

    // Decide whether the next cycle is a DONE cycle, for whom, and with
    // which result.  Stores and skipped accesses return zero data.
    always_comb begin
        w_fin     = 1'b0;
        w_finSel  = r_sel;
        w_finData = 32'h0000_0000;
        w_finErr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt && w_skip) begin
                    w_fin    = 1'b1;
                    w_finSel = w_pick;
                    w_finErr = w_misal;
                end
            end
            XFER: begin
                if ((r_cnt == w_lastIdx) && r_we) begin
                    w_fin = 1'b1;
                end
            end
            DRAIN: begin
                w_fin     = 1'b1;
                w_finData = w_ext;
            end
            default: ;
        endcase
    end

    // Main FSM with registered RAM port and result outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_sel      <= 1'b0;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= 2'b00;
            r_cnt      <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= 32'h0000_0000;
            r_rbuf     <= 32'h0000_0000;
            r_r0_done  <= 1'b0;
            r_r1_done  <= 1'b0;
            r_r0_rdata <= 32'h0000_0000;
            r_r1_rdata <= 32'h0000_0000;
            r_r0_err   <= 1'b0;
            r_r1_err   <= 1'b0;
            r_m_en     <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= 8'h00;
        end else begin
            r_r0_done <= 1'b0;
            r_r1_done <= 1'b0;

            if (w_fin) begin
                if (w_finSel) begin
                    r_r1_done  <= 1'b1;
                    r_r1_rdata <= w_finData;
                    r_r1_err   <= w_finErr;
                end else begin
                    r_r0_done  <= 1'b1;
                    r_r0_rdata <= w_finData;
                    r_r0_err   <= w_finErr;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_gnt) begin
                        r_sel   <= w_pick;
                        r_last  <= w_pick;
                        r_we    <= w_we;
                        r_size  <= w_size;
                        r_uns   <= w_uns;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_cnt   <= 2'd0;
                        if (w_skip) begin
                            r_state <= DONE;
                        end else begin
                            r_state   <= XFER;
                            r_m_en    <= 1'b1;
                            r_m_we    <= w_we;
                            r_m_addr  <= w_addr;
                            r_m_wdata <= w_wdata[7:0];
                        end
                    end
                end
                XFER: begin
                    if (!r_we && (r_cnt != 2'd0)) begin
                        r_rbuf <= w_ldata;
                    end
                    if (r_cnt == w_lastIdx) begin
                        r_m_en  <= 1'b0;
                        r_m_we  <= 1'b0;
                        r_state <= r_we ? DONE : DRAIN;
                    end else begin
                        // Address wraps modulo the RAM size.
                        r_cnt     <= r_cnt + 2'd1;
                        r_m_addr  <= r_addr + ADDR_W'(r_cnt) + ADDR_W'(1);
                        r_m_wdata <= r_wdata[{r_cnt + 2'd1, 3'b000} +: 8];
                    end
                end
                DRAIN: begin
                    r_rbuf  <= w_ldata;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_r0_gnt   = w_gnt0;
    assign o_r1_gnt   = w_gnt1;
    assign o_r0_done  = r_r0_done;
    assign o_r1_done  = r_r1_done;
    assign o_r0_rdata = r_r0_rdata;
    assign o_r1_rdata = r_r1_rdata;
    assign o_r0_err   = r_r0_err;
    assign o_r1_err   = r_r1_err;
    assign o_m_en     = r_m_en;
    assign o_m_we     = r_m_we;
    assign o_m_addr   = r_m_addr;
    assign o_m_wdata  = r_m_wdata;

endmodule

// File: tb/tb_mem_byte_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_byte_arbiter
//
// Self-checking bench for mem_byte_arbiter.  A 256-byte RAM model answers
// the byte port and logs every RAM cycle.  A table of single-requester
// accesses is replayed and checked for result, error flag, latency and the
// exact RAM cycle sequence; hand-written sequences cover reset, round-robin
// arbitration and reset in the middle of a store.
// ---------------------------------------------------------------------------
module tb_mem_byte_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        r0Req = 1'b0, r0We = 1'b0, r0Uns = 1'b0;
    logic [1:0]  r0Size = 2'b00;
    logic [31:0] r0Addr = 32'h0, r0Wdata = 32'h0;
    logic        r1Req = 1'b0, r1We = 1'b0, r1Uns = 1'b0;
    logic [1:0]  r1Size = 2'b00;
    logic [31:0] r1Addr = 32'h0, r1Wdata = 32'h0;

    logic        o_r0_gnt, o_r0_done, o_r0_err;
    logic [31:0] o_r0_rdata;
    logic        o_r1_gnt, o_r1_done, o_r1_err;
    logic [31:0] o_r1_rdata;
    logic        o_m_en, o_m_we;
    logic [7:0]  o_m_addr;
    logic [7:0]  o_m_wdata;
    logic [7:0]  mRdata = 8'h00;

    logic [7:0]  mem [256] = '{default: 8'h00};

    int          cyc = 0;
    int          doneCnt0 = 0;
    int          checks = 0;
    int          failures = 0;

    logic [7:0]  logAddr [$];
    logic        logWe [$];
    logic [7:0]  logData [$];
    int          logCyc [$];

    mem_byte_arbiter #(.ADDR_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_r0_req   (r0Req),
        .i_r0_we    (r0We),
        .i_r0_size  (r0Size),
        .i_r0_uns   (r0Uns),
        .i_r0_addr  (r0Addr),
        .i_r0_wdata (r0Wdata),
        .o_r0_gnt   (o_r0_gnt),
        .o_r0_done  (o_r0_done),
        .o_r0_rdata (o_r0_rdata),
        .o_r0_err   (o_r0_err),
        .i_r1_req   (r1Req),
        .i_r1_we    (r1We),
        .i_r1_size  (r1Size),
        .i_r1_uns   (r1Uns),
        .i_r1_addr  (r1Addr),
        .i_r1_wdata (r1Wdata),
        .o_r1_gnt   (o_r1_gnt),
        .o_r1_done  (o_r1_done),
        .o_r1_rdata (o_r1_rdata),
        .o_r1_err   (o_r1_err),
        .o_m_en     (o_m_en),
        .o_m_we     (o_m_we),
        .o_m_addr   (o_m_addr),
        .o_m_wdata  (o_m_wdata),
        .i_m_rdata  (mRdata)
    );

    always #5 clk = ~clk;

    // RAM model with one-cycle read latency; also logs each RAM cycle with
    // the number of the cycle in which the DUT presented it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_m_en === 1'b1) begin
            if (o_m_we) mem[o_m_addr] <= o_m_wdata;
            else        mRdata <= mem[o_m_addr];
            logAddr.push_back(o_m_addr);
            logWe.push_back(o_m_we);
            logData.push_back(o_m_wdata);
            logCyc.push_back(cyc);
        end
        if (o_r0_done === 1'b1) doneCnt0 <= doneCnt0 + 1;
    end

    typedef struct {
        logic        who;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
        int          expBytes;
    } vec_t;

    vec_t vecs [$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
        end
    endtask

    // Hold reset over one clock edge, check reset values, then release.
    task automatic applyReset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_ctrl", {24'h0, o_r0_gnt, o_r1_gnt, o_r0_done, o_r1_done,
                                 o_r0_err, o_r1_err, o_m_en, o_m_we}, 32'h0);
        checkOutput("rst_r0_rdata", o_r0_rdata, 32'h0);
        checkOutput("rst_r1_rdata", o_r1_rdata, 32'h0);
        checkOutput("rst_m_bus", {16'h0, o_m_addr, o_m_wdata}, 32'h0);
        @(posedge clk); #1; rst = 1'b0;
    endtask

    // One access by a single requester: request, wait for grant, drop the
    // request, wait for done.  Latency is counted from the grant cycle.
    task automatic applyStimulus(input logic who, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err,
                                 output int lat, output int tGnt, output int base);
        rdata = 32'hxxxx_xxxx;
        err   = 1'bx;
        lat   = -1;
        tGnt  = -1;
        base  = logAddr.size();
        @(posedge clk); #1;
        if (who) begin
            r1We = we; r1Size = size; r1Uns = uns; r1Addr = addr; r1Wdata = wdata; r1Req = 1'b1;
        end else begin
            r0We = we; r0Size = size; r0Uns = uns; r0Addr = addr; r0Wdata = wdata; r0Req = 1'b1;
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((who ? o_r1_gnt : o_r0_gnt) === 1'b1) begin
                tGnt = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        r0Req = 1'b0;
        r1Req = 1'b0;
        if (tGnt < 0) begin
            checkOutput("gnt_timeout", 32'h0, 32'h1);
            return;
        end
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((who ? o_r1_done : o_r0_done) === 1'b1) begin
                rdata = who ? o_r1_rdata : o_r0_rdata;
                err   = who ? o_r1_err : o_r0_err;
                lat   = cyc - tGnt;
                break;
            end
        end
        if (lat < 0) begin
            checkOutput("done_timeout", 32'h0, 32'h1);
            return;
        end
        @(negedge clk);
        checkOutput("done_pulse_width", {31'h0, who ? o_r1_done : o_r0_done}, 32'h0);
    endtask

    initial begin : mainTest
        vec_t        v;
        logic [31:0] rd;
        logic        er;
        int          lat, tG, base, nBytes, doneBefore;
        int          order [$];
        int          expOrd [4] = '{0, 1, 0, 1};
        logic        d0, d1, g0, g1;
        logic [7:0]  expByte;

        // who we size uns addr wdata expRdata expErr expLat expBytes
        vecs.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hA1B2_C3D4, 32'h0000_0000, 1'b0, 5, 4});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        32'hFFFF_FFA1, 1'b0, 3, 1});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        32'h0000_00A1, 1'b0, 3, 1});
        vecs.push_back('{1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        32'hFFFF_A1B2, 1'b0, 4, 2});
        vecs.push_back('{1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,        32'h0000_C3D4, 1'b0, 4, 2});
        vecs.push_back('{1'b0, 1'b0, 2'b10, 1'b0, 32'hABCD_0010, 32'h0,        32'hA1B2_C3D4, 1'b0, 6, 4});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'hDEAD_BE55, 32'h0000_0000, 1'b0, 2, 1});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'hCAFE_807F, 32'h0000_0000, 1'b0, 3, 2});
        vecs.push_back('{1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        32'h807F_0055, 1'b0, 6, 4});
        vecs.push_back('{1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,        32'hFFFF_807F, 1'b0, 4, 2});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0022, 32'h0,        32'h0000_007F, 1'b0, 3, 1});
        vecs.push_back('{1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b0, 1, 0});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_00FE, 32'hDEAD_BE11, 32'h0000_0000, 1'b0, 2, 1});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_00FF, 32'hDEAD_BE22, 32'h0000_0000, 1'b0, 2, 1});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0000, 32'hDEAD_BE33, 32'h0000_0000, 1'b0, 2, 1});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'hDEAD_BE44, 32'h0000_0000, 1'b0, 2, 1});
`ifdef MEM_ALIGN_CHECK_EN
        vecs.push_back('{1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        32'h0000_0000, 1'b1, 1, 0});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_00FE, 32'h0,        32'h0000_0000, 1'b1, 1, 0});
`else
        vecs.push_back('{1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        32'hFFFF_B2C3, 1'b0, 4, 2});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_00FE, 32'h0,        32'h4433_2211, 1'b0, 6, 4});
`endif

        applyReset();

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            applyStimulus(v.who, v.we, v.size, v.uns, v.addr, v.wdata, rd, er, lat, tG, base);
            checkOutput($sformatf("v%0d_rdata", k), rd, v.expRdata);
            checkOutput($sformatf("v%0d_err", k), {31'h0, er}, {31'h0, v.expErr});
            checkOutput($sformatf("v%0d_latency", k), 32'(lat), 32'(v.expLat));
            nBytes = logAddr.size() - base;
            checkOutput($sformatf("v%0d_ram_cycles", k), 32'(nBytes), 32'(v.expBytes));
            for (int i = 0; i < v.expBytes && i < nBytes; i++) begin
                expByte = v.addr[7:0] + 8'(i);
                checkOutput($sformatf("v%0d_b%0d_addr", k, i), {24'h0, logAddr[base + i]}, {24'h0, expByte});
                checkOutput($sformatf("v%0d_b%0d_we", k, i), {31'h0, logWe[base + i]}, {31'h0, v.we});
                checkOutput($sformatf("v%0d_b%0d_cycle", k, i), 32'(logCyc[base + i]), 32'(tG + 1 + i));
                if (v.we) begin
                    expByte = 8'((v.wdata >> (8 * i)) & 32'hFF);
                    checkOutput($sformatf("v%0d_b%0d_wdata", k, i), {24'h0, logData[base + i]}, {24'h0, expByte});
                end
            end
        end

        // Reset during the third byte cycle of a word store: only the first
        // two bytes reach the RAM and no done pulse follows.
        base = logAddr.size();
        doneBefore = doneCnt0;
        @(posedge clk); #1;
        r0We = 1'b1; r0Size = 2'b10; r0Uns = 1'b0; r0Addr = 32'h30; r0Wdata = 32'h1122_3344; r0Req = 1'b1;
        @(negedge clk);
        checkOutput("midrst_gnt", {31'h0, o_r0_gnt}, 32'h1);
        @(posedge clk); #1; r0Req = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_m_en", {31'h0, o_m_en}, 32'h0);
        repeat (4) @(negedge clk);
        checkOutput("midrst_bytes", 32'(logAddr.size() - base), 32'd2);
        checkOutput("midrst_no_done", 32'(doneCnt0 - doneBefore), 32'd0);
        checkOutput("midrst_mem", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, 32'h0000_3344);
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat, tG, base);
        checkOutput("midrst_next_rdata", rd, 32'h0000_3344);
        checkOutput("midrst_next_latency", 32'(lat), 32'd6);

        // Fresh reset (r0 rdata currently non-zero), then simultaneous
        // requests twice: grants must alternate r0, r1, r0, r1.
        applyReset();
        for (int round = 0; round < 2; round++) begin
            @(posedge clk); #1;
            r0We = 1'b0; r0Size = 2'b00; r0Uns = 1'b0; r0Addr = 32'h13; r0Req = 1'b1;
            r1We = 1'b0; r1Size = 2'b00; r1Uns = 1'b1; r1Addr = 32'h10; r1Req = 1'b1;
            d0 = 1'b0;
            d1 = 1'b0;
            for (int n = 0; n < 40 && !(d0 && d1); n++) begin
                @(negedge clk);
                g0 = o_r0_gnt;
                g1 = o_r1_gnt;
                if (g0 === 1'b1) order.push_back(0);
                if (g1 === 1'b1) order.push_back(1);
                if (o_r0_done === 1'b1) begin
                    d0 = 1'b1;
                    checkOutput("arb_r0_rdata", o_r0_rdata, 32'hFFFF_FFA1);
                end
                if (o_r1_done === 1'b1) begin
                    d1 = 1'b1;
                    checkOutput("arb_r1_rdata", o_r1_rdata, 32'h0000_00D4);
                end
                @(posedge clk); #1;
                if (g0 === 1'b1) r0Req = 1'b0;
                if (g1 === 1'b1) r1Req = 1'b0;
            end
            r0Req = 1'b0;
            r1Req = 1'b0;
            if (!(d0 && d1)) checkOutput("arb_timeout", 32'h0, 32'h1);
        end
        checkOutput("arb_grant_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++) begin
            checkOutput($sformatf("arb_order_%0d", i), 32'(order[i]), 32'(expOrd[i]));
        end

        // r1 won last; a lone r1 request must still be granted.
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat, tG, base);
        checkOutput("lone_r1_rdata", rd, 32'h0000_00A1);
        checkOutput("lone_r1_latency", 32'(lat), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
